led_event_fifo: RTL and testbench



---
 rtl/led_event_fifo_if.sv | 21 ++
 rtl/led_event_fifo.sv | 103 ++++++++++
 tb/tb_led_event_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_event_fifo_if.sv
// Valid/ready event stream carrying {timestamp, value} words.
// The producer drives valid/data; the consumer drives ready.
interface led_event_fifo_if #(
    parameter int unsigned W = 32
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/led_event_fifo.sv
// Detects value changes on the LED bus and queues them with a
// free-running timestamp in a show-ahead FIFO drained by a stream.
module led_event_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TS_W   = 24,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [DATA_W-1:0] led_in,
    led_event_fifo_if.master  m,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       overflow_cnt
);
    localparam int unsigned EW = TS_W + DATA_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] led_s_q, led_s_d;
    logic [DATA_W-1:0] led_last_q, led_last_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [15:0]       ovf_q, ovf_d;

    logic evt;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // Next-state: change detect, FIFO push/pop, overflow counting.
    // led_last always follows led_s so a re-enable never reports a
    // change that happened while capture was disabled.
    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        led_s_d    = led_in;
        led_last_d = led_s_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;

        evt  = enable && (led_s_q != led_last_q);
        pop  = (level_q != '0) && m.ready;
        full = (level_q == FULL_LVL);
        push = evt && (!full || pop);
        drop = evt && full && !pop;

        if (push) begin
            mem_d[wr_ptr_q] = {ts_q, led_s_q};
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // State registers; storage is cleared too so the head reads zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ts_q       <= '0;
            led_s_q    <= '0;
            led_last_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= '0;
        end else begin
            ts_q       <= ts_d;
            led_s_q    <= led_s_d;
            led_last_q <= led_last_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
        end
    end

    assign m.valid      = (level_q != '0);
    assign m.data       = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_led_event_fifo.sv
// Self-checking bench: vector table, directed corner cases and a
// randomized run against a queue-based reference model.
module tb_led_event_fifo;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        en;
    logic        rdy;
    logic [7:0]  led;
    logic [3:0]  level;
    logic [15:0] ovf;

    logic        rst2;
    logic        en2;
    logic        rdy2;
    logic [7:0]  led2;
    logic [3:0]  level2;
    logic [15:0] ovf2;

    led_event_fifo_if #(.W(32)) bus ();
    led_event_fifo_if #(.W(12)) bus2 ();

    assign bus.ready  = rdy;
    assign bus2.ready = rdy2;

    led_event_fifo dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (en),
        .led_in       (led),
        .m            (bus),
        .level        (level),
        .overflow_cnt (ovf)
    );

    led_event_fifo #(.TS_W(4)) dut2 (
        .CLK          (CLK),
        .RST          (rst2),
        .enable       (en2),
        .led_in       (led2),
        .m            (bus2),
        .level        (level2),
        .overflow_cnt (ovf2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an event list plus the spec's rules per edge.
    logic [31:0] q[$];
    logic [23:0] ts_m;
    logic [7:0]  ls_m;
    logic [7:0]  last_m;
    logic [15:0] ovf_m;

    task automatic model_reset();
        q.delete();
        ts_m   = '0;
        ls_m   = '0;
        last_m = '0;
        ovf_m  = '0;
    endtask

    task automatic model_edge();
        bit ev;
        bit pp;
        bit ps;
        ev = en && (ls_m != last_m);
        pp = (q.size() > 0) && rdy;
        ps = ev && ((q.size() < 8) || pp);
        if (pp) void'(q.pop_front());
        if (ps) q.push_back({ts_m, ls_m});
        else if (ev && ovf_m != 16'hFFFF) ovf_m = ovf_m + 16'd1;
        last_m = ls_m;
        ls_m   = led;
        ts_m   = ts_m + 24'd1;
    endtask

    task automatic model_cmp();
        chk("m_valid", bus.valid, q.size() != 0);
        chk("level", level, q.size());
        chk("overflow_cnt", ovf, ovf_m);
        if (q.size() != 0) chk("m_data", bus.data, q[0]);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        model_cmp();
    endtask

    typedef struct {
        logic        en;
        logic [7:0]  led;
        logic        rdy;
        logic        exp_v;
        logic [3:0]  exp_lvl;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[31];

    initial begin
        logic [23:0] prev_ts;
        logic [7:0]  exp_vals[8];
        int          thr;

        for (int i = 0; i < 31; i++) begin
            tbl[i] = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 32'h0};
        end
        tbl[20].led = 8'h05;
        tbl[21].led = 8'h05;
        tbl[21].exp_v = 1'b1;
        tbl[21].exp_lvl = 4'd1;
        tbl[21].exp_data = {24'd21, 8'h05};
        tbl[22].led = 8'h05;
        tbl[23] = '{1'b0, 8'h01, 1'b1, 1'b0, 4'd0, 32'h0};
        tbl[24] = '{1'b0, 8'h02, 1'b1, 1'b0, 4'd0, 32'h0};
        tbl[25] = '{1'b0, 8'h03, 1'b1, 1'b0, 4'd0, 32'h0};
        tbl[26] = '{1'b0, 8'h03, 1'b1, 1'b0, 4'd0, 32'h0};
        for (int i = 27; i < 31; i++) tbl[i].led = 8'h03;

        RST  = 1'b0;
        en   = 1'b1;
        led  = 8'h00;
        rdy  = 1'b1;
        rst2 = 1'b0;
        en2  = 1'b1;
        led2 = 8'h00;
        rdy2 = 1'b0;
        model_reset();
        #2;
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_ovf", ovf, 16'd0);
        chk("rst_data", bus.data, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 31; i++) begin
            en  = tbl[i].en;
            led = tbl[i].led;
            rdy = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_valid", i), bus.valid, tbl[i].exp_v);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_lvl);
            chk($sformatf("tbl%0d_ovf", i), ovf, 16'd0);
            if (tbl[i].exp_v)
                chk($sformatf("tbl%0d_data", i), bus.data,
                    tbl[i].exp_data);
        end

        // Overflow: ten changes into an eight-deep FIFO.
        rdy = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            led = 8'h10 + 8'(k);
            step();
        end
        step();
        chk("ovf_level", level, 4'd8);
        chk("ovf_cnt", ovf, 16'd2);
        chk("ovf_head", bus.data[7:0], 8'h10);
        step();
        led = 8'h55;
        step();
        rdy = 1'b1;
        step();
        chk("full_pp_level", level, 4'd8);
        chk("full_pp_ovf", ovf, 16'd2);
        chk("full_pp_head", bus.data[7:0], 8'h11);

        for (int j = 0; j < 7; j++) exp_vals[j] = 8'h11 + 8'(j);
        exp_vals[7] = 8'h55;
        prev_ts = bus.data[31:8];
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d_val", j), bus.data[7:0], exp_vals[j]);
            if (j > 0)
                chk($sformatf("drain%0d_ts_inc", j),
                    bus.data[31:8] > prev_ts, 1'b1);
            prev_ts = bus.data[31:8];
            step();
        end
        chk("drained_valid", bus.valid, 1'b0);

        // Reset in the middle of a drain.
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            led = 8'h60 + 8'(k);
            step();
        end
        step();
        chk("pre_rst_level", level, 4'd3);
        rdy = 1'b1;
        step();
        #2;
        RST = 1'b0;
        #1;
        chk("midrst_valid", bus.valid, 1'b0);
        chk("midrst_level", level, 4'd0);
        chk("midrst_ovf", ovf, 16'd0);
        model_reset();
        led = 8'h00;
        @(negedge CLK);
        RST = 1'b1;

        // Timestamp wrap on the 4-bit timestamp build.
        rst2 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            led2 = (k < 15) ? 8'h00 : (k < 17) ? 8'hA0 : 8'hB1;
            step();
        end
        chk("wrap_level", level2, 4'd2);
        chk("wrap_valid", bus2.valid, 1'b1);
        chk("wrap_first", bus2.data, {4'hF, 8'hA0});
        rdy2 = 1'b1;
        step();
        rdy2 = 1'b0;
        chk("wrap_second", bus2.data, {4'h1, 8'hB1});
        #2;
        rst2 = 1'b0;
        #1;
        chk("wrap_rst_valid", bus2.valid, 1'b0);
        chk("wrap_rst_level", level2, 4'd0);

        // Randomized run against the model.
        for (int blk = 0; blk < 4; blk++) begin
            thr = (blk == 0) ? 10 : (blk == 1) ? 50 : (blk == 2) ? 90 : 30;
            for (int c = 0; c < 100; c++) begin
                en  = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 2) == 0) led = 8'($urandom);
                rdy = ($urandom_range(0, 99) < thr);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
